// File: rtl/pll_ctrl_pkg.sv
// Shared types for the PLL reset controller: state encoding, default counter width
// and a small parameter helper.
package pll_ctrl_pkg;

   typedef enum logic [2:0] {
      PLL_RESET = 3'd0,
      WAIT_LOCK = 3'd1,
      HOLD_SYS  = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } state_e;

   localparam int unsigned CNT_W_DEFAULT = 8;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchronizer with asynchronous active-high reset.
module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_ctrl.sv
// PLL reset sequencer: pulses pll_rst, waits for stable lock, then releases sys_rst.
// Macro PLL_RESET_CTRL_AUTO_RELOCK_EN: lock loss / timeout restart the PLL instead of latching FAULT.
module pll_reset_ctrl
   import pll_ctrl_pkg::*;
#(
   parameter int unsigned PLL_RST_CYCLES     = 16,
   parameter int unsigned LOCK_STABLE_CYCLES = 1024,
   parameter int unsigned SYS_RST_HOLD       = 16,
   parameter int unsigned LOCK_TIMEOUT       = 65536,
   parameter int unsigned CNT_W              = CNT_W_DEFAULT
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] relock_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int unsigned MAX_P = max_u(max_u(PLL_RST_CYCLES, LOCK_STABLE_CYCLES),
                                         max_u(SYS_RST_HOLD, LOCK_TIMEOUT));
   localparam int unsigned TMR_W = $clog2(MAX_P) + 1;

   localparam logic [TMR_W-1:0] T_PLL       = TMR_W'(PLL_RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] T_TIMEOUT   = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] T_HOLD      = TMR_W'(SYS_RST_HOLD - 1);
   localparam logic [TMR_W-1:0] T_STABLE_M1 = TMR_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_MAX     = {CNT_W{1'b1}};

`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
   localparam state_e FAIL_STATE = PLL_RESET;
`else
   localparam state_e FAIL_STATE = FAULT;
`endif

   logic             lk_s;
   state_e           state_q, state_nxt;
   logic [TMR_W-1:0] tmr_q, tmr_nxt;
   logic [TMR_W-1:0] stable_q, stable_nxt;
   logic [CNT_W-1:0] relock_nxt, timeout_nxt;
   logic             pll_rst_nxt, sys_rst_nxt, ready_nxt;

   sync_2ff u_lock_sync (
      .clk (refclk),
      .rst (rst),
      .d   (pll_locked),
      .q   (lk_s)
   );

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q     <= PLL_RESET;
         tmr_q       <= T_PLL;
         stable_q    <= '0;
         relock_cnt  <= '0;
         timeout_cnt <= '0;
         pll_rst     <= 1'b1;
         sys_rst     <= 1'b1;
         ready       <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         tmr_q       <= tmr_nxt;
         stable_q    <= stable_nxt;
         relock_cnt  <= relock_nxt;
         timeout_cnt <= timeout_nxt;
         pll_rst     <= pll_rst_nxt;
         sys_rst     <= sys_rst_nxt;
         ready       <= ready_nxt;
      end
   end

   // Sequencing; every path into PLL_RESET reloads the timer with the pulse width.
   always_comb begin
      state_nxt   = state_q;
      tmr_nxt     = tmr_q;
      stable_nxt  = stable_q;
      relock_nxt  = relock_cnt;
      timeout_nxt = timeout_cnt;

      case (state_q)
         PLL_RESET: begin
            stable_nxt = '0;
            if (tmr_q == '0) begin
               state_nxt = WAIT_LOCK;
               tmr_nxt   = T_TIMEOUT;
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end
         WAIT_LOCK: begin
            stable_nxt = lk_s ? stable_q + TMR_W'(1) : '0;
            // Stable completion takes priority over a coincident timeout.
            if (lk_s && (stable_q == T_STABLE_M1)) begin
               state_nxt  = HOLD_SYS;
               tmr_nxt    = T_HOLD;
               stable_nxt = '0;
            end else if (tmr_q == '0) begin
               state_nxt   = FAIL_STATE;
               tmr_nxt     = T_PLL;
               timeout_nxt = (timeout_cnt == CNT_MAX) ? timeout_cnt : timeout_cnt + CNT_W'(1);
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end
         HOLD_SYS: begin
            if (!lk_s) begin
               state_nxt = PLL_RESET;
               tmr_nxt   = T_PLL;
            end else if (tmr_q == '0) begin
               state_nxt = RUN;
            end else begin
               tmr_nxt = tmr_q - TMR_W'(1);
            end
         end
         RUN: begin
            if (!lk_s) begin
               state_nxt  = FAIL_STATE;
               tmr_nxt    = T_PLL;
               relock_nxt = (relock_cnt == CNT_MAX) ? relock_cnt : relock_cnt + CNT_W'(1);
            end
         end
         FAULT: begin
            state_nxt = FAULT;
         end
         default: begin
            state_nxt = PLL_RESET;
            tmr_nxt   = T_PLL;
         end
      endcase

      pll_rst_nxt = (state_nxt == PLL_RESET) || (state_nxt == FAULT);
      sys_rst_nxt = (state_nxt != RUN);
      ready_nxt   = (state_nxt == RUN);
   end

endmodule

// File: tb/tb_pll_reset_ctrl.sv
// Directed bench for pll_reset_ctrl with small timing parameters; cycle c is the
// interval after the c-th refclk edge following rst release (inputs driven, outputs sampled at +1).
module tb_pll_reset_ctrl;

   localparam int unsigned CNT_W = 4;

   logic             refclk = 1'b0;
   logic             rst    = 1'b1;
   logic             pll_locked = 1'b0;
   logic             pll_rst, sys_rst, ready;
   logic [CNT_W-1:0] relock_cnt, timeout_cnt;

   int unsigned cyc    = 0;
   int unsigned passed = 0;
   int unsigned total  = 0;

   pll_reset_ctrl #(
      .PLL_RST_CYCLES     (4),
      .LOCK_STABLE_CYCLES (8),
      .SYS_RST_HOLD       (4),
      .LOCK_TIMEOUT       (32),
      .CNT_W              (CNT_W)
   ) dut (
      .refclk      (refclk),
      .rst         (rst),
      .pll_locked  (pll_locked),
      .pll_rst     (pll_rst),
      .sys_rst     (sys_rst),
      .ready       (ready),
      .relock_cnt  (relock_cnt),
      .timeout_cnt (timeout_cnt)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s @cyc %0d: got %0h, want %0h", tag, cyc, obs, exp);
   endtask

   task automatic check_out(input string tag, input logic p, input logic s, input logic r,
                            input logic [CNT_W-1:0] rc, input logic [CNT_W-1:0] tc);
      check({tag, ".pll_rst"},     8'(pll_rst),     8'(p));
      check({tag, ".sys_rst"},     8'(sys_rst),     8'(s));
      check({tag, ".ready"},       8'(ready),       8'(r));
      check({tag, ".relock_cnt"},  8'(relock_cnt),  8'(rc));
      check({tag, ".timeout_cnt"}, 8'(timeout_cnt), 8'(tc));
   endtask

   task automatic step_to(input int unsigned c);
      while (cyc < c) begin
         @(posedge refclk);
         #1;
         cyc++;
      end
   endtask

   // Pulse rst, then release it just after an edge; that interval becomes cycle 0.
   task automatic do_reset();
      @(posedge refclk);
      #1;
      rst = 1'b1;
      @(posedge refclk);
      #1;
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      // Reset values while rst is held
      #12;
      check_out("rst_hold", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);

      // A: lock rises when pll_rst falls -> release at 4+2+8+4 = 18
      do_reset();
      check_out("a_c0", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(3);
      check("a_c3.pll_rst", 8'(pll_rst), 8'd1);
      step_to(4);
      check("a_c4.pll_rst", 8'(pll_rst), 8'd0);
      pll_locked = 1'b1;
      step_to(17);
      check_out("a_c17", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(18);
      check_out("a_c18", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

      // B: lock drop in RUN at cycle 20 is seen two cycles later
      step_to(20);
      pll_locked = 1'b0;
      step_to(22);
      check_out("b_c22", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);
      step_to(23);
      check_out("b_c23", 1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
      step_to(26);
      check("b_c26.pll_rst", 8'(pll_rst), 8'd1);
      step_to(27);
      check("b_c27.pll_rst", 8'(pll_rst), 8'd0);
      pll_locked = 1'b1;
      step_to(40);
      check_out("b_c40", 1'b0, 1'b1, 1'b0, 4'd1, 4'd0);
      step_to(41);
      check_out("b_c41", 1'b0, 1'b0, 1'b1, 4'd1, 4'd0);
`else
      step_to(25);
      pll_locked = 1'b1;
      step_to(60);
      check_out("b_fault_c60", 1'b1, 1'b1, 1'b0, 4'd1, 4'd0);
`endif

      // D: async rst in HOLD_SYS (cycles 14..17) takes effect within the cycle
      pll_locked = 1'b0;
      do_reset();
      check("d_c0.relock_cnt", 8'(relock_cnt), 8'd0);
      step_to(4);
      pll_locked = 1'b1;
      step_to(15);
      check_out("d_hold_c15", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      #2;
      rst = 1'b1;
      #1;
      check_out("d_async", 1'b1, 1'b1, 1'b0, 4'd0, 4'd0);

      // C: one-cycle lk_s glitch at stable-window cycle 3 delays release to 22
      pll_locked = 1'b0;
      do_reset();
      step_to(4);
      pll_locked = 1'b1;
      step_to(7);
      pll_locked = 1'b0;
      step_to(8);
      pll_locked = 1'b1;
      step_to(18);
      check_out("c_c18", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(21);
      check("c_c21.sys_rst", 8'(sys_rst), 8'd1);
      step_to(22);
      check_out("c_c22", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

      // E: lock never arrives; timeout after 32 WAIT_LOCK cycles
      pll_locked = 1'b0;
      do_reset();
      step_to(35);
      check_out("e_c35", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(36);
      check_out("e_c36", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
`ifdef PLL_RESET_CTRL_AUTO_RELOCK_EN
      step_to(72);
      check_out("e_c72", 1'b1, 1'b1, 1'b0, 4'd0, 4'd2);
      step_to(578);
      check_out("e_c578", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
      step_to(611);
      check_out("e_c611", 1'b0, 1'b1, 1'b0, 4'd0, 4'd15);
      step_to(613);
      check_out("e_c613", 1'b1, 1'b1, 1'b0, 4'd0, 4'd15);
`else
      step_to(100);
      check_out("e_fault_c100", 1'b1, 1'b1, 1'b0, 4'd0, 4'd1);
`endif

      // F: stable count completes on the exact timeout cycle (35) -> HOLD_SYS
      pll_locked = 1'b0;
      do_reset();
      step_to(26);
      pll_locked = 1'b1;
      step_to(35);
      check_out("f_c35", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(36);
      check_out("f_c36", 1'b0, 1'b1, 1'b0, 4'd0, 4'd0);
      step_to(40);
      check_out("f_c40", 1'b0, 1'b0, 1'b1, 4'd0, 4'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
